digital_lock_param: RTL and testbench
=====================================

# digital_lock_param

Parametrised successor to the four-digit lock FSM: a DIGITS-long, DIGIT_W-bit passcode lock with clear, relock-by-code, two-step password change and failed-attempt lockout. Sits between the debounced button/switch front end and the binary_to_segment SSD driver. It emits 5-bit glyph codes per display position plus status LEDs.

## Interface
- DIGITS, 4: passcode length and display positions; legal range 4..8.
- DIGIT_W, 4: bits per digit taken from sw; legal range 1..4.
- MAX_TRIES, 3: consecutive failed unlocks before lockout; at least 1.
- LOCKOUT_TICKS, 10: lockout duration in ticks.
- TICK_DIV, 50_000_000: clk cycles per tick; at least 2.
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- clr  in  1  one-cycle pulse; discard digits entered so far.
- ent  in  1  one-cycle pulse; start entry or capture a digit.
- change  in  1  one-cycle pulse; request a password change, honoured only in UNLOCKED.
- sw  in  DIGIT_W  current digit value.
- led  out  6  status flags; [0] locked, [1] unlocked, [2] entry active, [3] change mode, [4] lockout, [5] last unlock failed.
- glyph  out  5*DIGITS  glyph codes, position 0 in the MSBs.

## Operation
- States:
  - LOCKED
  - ENTER_UNLOCK
  - UNLOCKED
  - ENTER_LOCK
  - ENTER_NEW
  - CONFIRM_NEW
  - LOCKOUT
- Digit index idx runs 0..DIGITS-1. The entry buffer buf holds DIGITS*DIGIT_W bits.
- LOCKED, ent: go to ENTER_UNLOCK with idx=0 and buf cleared. This ent captures no digit.
- UNLOCKED, change: go to ENTER_NEW.
- UNLOCKED, ent: go to ENTER_LOCK.
- UNLOCKED, change and ent in the same cycle: change wins.
- Any ENTER_*/CONFIRM state, ent with idx<DIGITS-1: buf[idx]<=sw, idx++.
- ent with idx==DIGITS-1 completes the code. The completed code is buf with its last digit equal to sw, evaluated in the same cycle:
  - ENTER_UNLOCK, match: go to UNLOCKED, tries<=0, led[5]<=0.
  - ENTER_UNLOCK, mismatch: tries++, led[5]<=1. If tries reaches MAX_TRIES go to LOCKOUT, otherwise go to LOCKED.
  - ENTER_LOCK, match: go to LOCKED.
  - ENTER_LOCK, mismatch: go to UNLOCKED. No try is counted.
  - ENTER_NEW: cand<=code, go to CONFIRM_NEW.
  - CONFIRM_NEW, match with cand: password<=cand, go to UNLOCKED.
  - CONFIRM_NEW, mismatch: go to UNLOCKED; password is unchanged.
- clr in any entry state: idx<=0, buf cleared, state held. clr takes priority over ent in the same cycle.
- clr and change are ignored outside the states listed above.
- LOCKOUT: ent, clr and change are ignored. Count LOCKOUT_TICKS ticks, then go to LOCKED with tries<=0.
- Display, with messages left-aligned and blank-padded:
  - LOCKED shows "CLSd".
  - UNLOCKED shows "OPEn".
  - Entry states: positions <idx show dash, position idx shows sw blinking (blank when blink phase is 1), positions >idx show blank.
  - LOCKOUT shows all dashes, blinking.
- Glyph codes:
  - 0..15: hex digit, sw zero-extended to 5 bits.
  - 16: blank. 17: dash.
  - 18: C. 19: L. 20: S. 21: d.
  - 22: O. 23: P. 24: E. 25: n.

## Timing
- Reset values:
  - state LOCKED, password all-zero, tries 0, idx 0.
  - buf and cand all-zero, blink phase 0, tick counter 0.
  - led=6'b000001, glyph="CLSd".
- rst asserted mid-entry or mid-lockout returns everything to reset values, including password.
- State and registers update on the clk edge that samples ent, clr or change.
- led and glyph are registered from the current state: they reflect a transition one cycle after the state changes, two edges after the input pulse.
- tick is a single-cycle pulse every TICK_DIV cycles, free-running from reset.
- Blink phase toggles on each tick.
- A LOCKOUT of N ticks lasts between N-1 and N tick periods, because the tick counter is not re-phased on entry.

## Configuration
- LOCK_LOCKOUT_EN defined: tries counter, LOCKOUT state and led[4] are implemented as described above.
- LOCK_LOCKOUT_EN undefined:
  - A mismatch in ENTER_UNLOCK always goes to LOCKED.
  - The tries counter and LOCKOUT state are not built, and led[4] is tied to 0.
  - led[5] still tracks the last unlock failure.

## Structure
- Package lock_pkg holds:
  - the state enum;
  - the glyph code localparams (G_BLANK, G_DASH, G_C, G_L, G_S, G_D, G_O, G_P, G_E, G_N);
  - the LED bit index constants.
- One sub-module, lock_tick_gen: TICK_DIV counter producing the tick pulse and blink phase, reset by rst.
- Everything else (FSM, datapath, glyph mux) lives in digital_lock_param.

## Test plan
- Bench parameters: DIGITS=4, DIGIT_W=4, TICK_DIV=4.
- Unlock: reset, ent, enter 0,0,0,0 with ent each -> 2 cycles after the last ent, led=6'b000010 and glyph="OPEn".
- Change: from UNLOCKED, change, enter 1,2,3,4, confirm 1,2,3,4 -> then ent plus 1,2,3,4 gives LOCKED; ent plus 0,0,0,0 from LOCKED fails with led[5]=1.
- Confirm mismatch: new 1,2,3,4 then confirm 1,2,3,5 -> UNLOCKED, password still 0000.
- Clear: enter 9,9 then clr with ent asserted in the same cycle -> idx=0, no digit captured; then 0,0,0,0 unlocks.
- Lockout (LOCK_LOCKOUT_EN, MAX_TRIES=3, LOCKOUT_TICKS=2): three wrong codes -> led[4]=1 and ents ignored; after 2 ticks, LOCKED with tries=0.
- Reset mid-entry: assert rst after two digits in ENTER_NEW -> next cycle led=6'b000001, glyph="CLSd", password 0000.

Source files
------------

// File: rtl/digital_lock_param_pkg.sv
// Shared types and constants for the parametrised passcode lock.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, 5-bit glyph codes for the SSD driver, led bit indices.
package lock_pkg;

  typedef enum logic [2:0] {
    S_LOCKED,
    S_ENTER_UNLOCK,
    S_UNLOCKED,
    S_ENTER_LOCK,
    S_ENTER_NEW,
    S_CONFIRM_NEW,
    S_LOCKOUT
  } state_t;

  // Glyph codes 0..15 are hex digits; the rest are fixed symbols.
  localparam logic [4:0] G_BLANK = 5'd16;
  localparam logic [4:0] G_DASH  = 5'd17;
  localparam logic [4:0] G_C     = 5'd18;
  localparam logic [4:0] G_L     = 5'd19;
  localparam logic [4:0] G_S     = 5'd20;
  localparam logic [4:0] G_D     = 5'd21;
  localparam logic [4:0] G_O     = 5'd22;
  localparam logic [4:0] G_P     = 5'd23;
  localparam logic [4:0] G_E     = 5'd24;
  localparam logic [4:0] G_N     = 5'd25;

  localparam int LED_LOCKED   = 0;
  localparam int LED_UNLOCKED = 1;
  localparam int LED_ENTRY    = 2;
  localparam int LED_CHANGE   = 3;
  localparam int LED_LOCKOUT  = 4;
  localparam int LED_FAIL     = 5;

endpackage

// File: rtl/digital_lock_param_if.sv
// Button/switch inputs and display/status outputs of the passcode lock.
// Latency: n/a (wiring only).
// Backpressure: none; clr/ent/change are single-cycle pulses.
// Signals: clr, ent, change (pulses), sw (digit value), led[5:0], glyph (5 bits per position).
interface digital_lock_param_if #(
  parameter int DIGITS  = 4,
  parameter int DIGIT_W = 4
);
  logic                  clr;
  logic                  ent;
  logic                  change;
  logic [DIGIT_W-1:0]    sw;
  logic [5:0]            led;
  logic [5*DIGITS-1:0]   glyph;

  modport master (output clr, ent, change, sw, input led, glyph);
  modport slave  (input clr, ent, change, sw, output led, glyph);
endinterface

// File: rtl/digital_lock_param_tick_gen.sv
// Free-running tick divider and blink phase for the lock display/lockout timer.
// Latency: tick is combinational from the counter; blink toggles on the edge after each tick.
// Backpressure: none.
// Ports: clk, rst (async, active-high), tick (1-cycle pulse every TICK_DIV clks), blink.
module lock_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick,
  output logic blink
);
  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      blink <= 1'b0;
    end else if (tick) begin
      cnt_q <= '0;
      blink <= ~blink;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end
endmodule

// File: rtl/digital_lock_param.sv
// DIGITS-long passcode lock: unlock/relock by code, two-step password change, optional lockout.
// Latency: state moves on the edge sampling a pulse; led/glyph follow one cycle later.
// Backpressure: none; pulses not meaningful in the current state are dropped.
// Ports: clk, rst (async, active-high), bus (slave: clr/ent/change/sw in, led/glyph out).
// Build option: LOCK_LOCKOUT_EN adds the failed-try counter and LOCKOUT state.
module digital_lock_param
  import lock_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int DIGIT_W       = 4,
  parameter int MAX_TRIES     = 3,
  parameter int LOCKOUT_TICKS = 10,
  parameter int TICK_DIV      = 50_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  digital_lock_param_if.slave  bus
);
  localparam int CW = DIGITS * DIGIT_W;
  localparam int IW = $clog2(DIGITS);

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       ent_buf_q, ent_buf_d;
  logic [CW-1:0]       cand_q, cand_d;
  logic [CW-1:0]       pass_q, pass_d;
  logic                fail_q, fail_d;
  logic [CW-1:0]       code;
  logic [5:0]          led_q, led_d;
  logic [5*DIGITS-1:0] glyph_q, glyph_d;
  logic                tick, blink;

`ifdef LOCK_LOCKOUT_EN
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int LW = $clog2(LOCKOUT_TICKS + 1);
  logic [TW-1:0] tries_q, tries_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
`else
  // Without lockout the tick and its sizing parameters have no consumer.
  logic unused_cfg;
  assign unused_cfg = ^{tick, MAX_TRIES[0], LOCKOUT_TICKS[0]};
`endif

  // Left-aligned message, remaining positions blank.
  function automatic logic [5*DIGITS-1:0] msg(input logic [19:0] m);
    logic [5*DIGITS-1:0] r;
    for (int p = 0; p < DIGITS; p++) r[p*5 +: 5] = G_BLANK;
    r[5*DIGITS-1 -: 20] = m;
    return r;
  endfunction

  lock_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .blink (blink)
  );

  // The final digit is compared straight from sw, so completion needs no extra cycle.
  always_comb begin
    code = ent_buf_q;
    code[(DIGITS-1)*DIGIT_W +: DIGIT_W] = bus.sw;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ent_buf_d = ent_buf_q;
    cand_d    = cand_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
`ifdef LOCK_LOCKOUT_EN
    tries_d    = tries_q;
    lock_cnt_d = lock_cnt_q;
`endif
    case (state_q)
      S_LOCKED: begin
        if (bus.ent) begin
          state_d   = S_ENTER_UNLOCK;
          idx_d     = '0;
          ent_buf_d = '0;
        end
      end
      S_UNLOCKED: begin
        if (bus.change) begin
          state_d   = S_ENTER_NEW;
          idx_d     = '0;
          ent_buf_d = '0;
        end else if (bus.ent) begin
          state_d   = S_ENTER_LOCK;
          idx_d     = '0;
          ent_buf_d = '0;
        end
      end
      S_ENTER_UNLOCK, S_ENTER_LOCK, S_ENTER_NEW, S_CONFIRM_NEW: begin
        if (bus.clr) begin
          idx_d     = '0;
          ent_buf_d = '0;
        end else if (bus.ent) begin
          if (idx_q != IW'(DIGITS - 1)) begin
            ent_buf_d[int'(idx_q)*DIGIT_W +: DIGIT_W] = bus.sw;
            idx_d = idx_q + IW'(1);
          end else begin
            idx_d     = '0;
            ent_buf_d = '0;
            case (state_q)
              S_ENTER_UNLOCK: begin
                if (code == pass_q) begin
                  state_d = S_UNLOCKED;
                  fail_d  = 1'b0;
`ifdef LOCK_LOCKOUT_EN
                  tries_d = '0;
`endif
                end else begin
                  fail_d  = 1'b1;
                  state_d = S_LOCKED;
`ifdef LOCK_LOCKOUT_EN
                  tries_d = tries_q + TW'(1);
                  if (tries_d == TW'(MAX_TRIES)) begin
                    state_d    = S_LOCKOUT;
                    lock_cnt_d = '0;
                  end
`endif
                end
              end
              S_ENTER_LOCK: state_d = (code == pass_q) ? S_LOCKED : S_UNLOCKED;
              S_ENTER_NEW: begin
                cand_d  = code;
                state_d = S_CONFIRM_NEW;
              end
              default: begin
                if (code == cand_q) pass_d = cand_q;
                state_d = S_UNLOCKED;
              end
            endcase
          end
        end
      end
`ifdef LOCK_LOCKOUT_EN
      S_LOCKOUT: begin
        // Counter is not re-phased on entry, so the first tick may come early.
        if (tick) begin
          if (lock_cnt_q == LW'(LOCKOUT_TICKS - 1)) begin
            state_d    = S_LOCKED;
            tries_d    = '0;
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + LW'(1);
          end
        end
      end
`endif
      default: state_d = S_LOCKED;
    endcase
  end

  always_comb begin
    glyph_d = msg({G_C, G_L, G_S, G_D});
    led_d   = '0;
    led_d[LED_FAIL] = fail_q;
    case (state_q)
      S_LOCKED:   led_d[LED_LOCKED] = 1'b1;
      S_UNLOCKED: begin
        led_d[LED_UNLOCKED] = 1'b1;
        glyph_d = msg({G_O, G_P, G_E, G_N});
      end
      S_LOCKOUT: begin
`ifdef LOCK_LOCKOUT_EN
        led_d[LED_LOCKOUT] = 1'b1;
`endif
        for (int p = 0; p < DIGITS; p++)
          glyph_d[(DIGITS-1-p)*5 +: 5] = blink ? G_BLANK : G_DASH;
      end
      default: begin
        led_d[LED_ENTRY]  = 1'b1;
        led_d[LED_CHANGE] = (state_q == S_ENTER_NEW) || (state_q == S_CONFIRM_NEW);
        for (int p = 0; p < DIGITS; p++) begin
          if (p < int'(idx_q))
            glyph_d[(DIGITS-1-p)*5 +: 5] = G_DASH;
          else if (p == int'(idx_q))
            glyph_d[(DIGITS-1-p)*5 +: 5] = blink ? G_BLANK : 5'(bus.sw);
          else
            glyph_d[(DIGITS-1-p)*5 +: 5] = G_BLANK;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_LOCKED;
      idx_q     <= '0;
      ent_buf_q <= '0;
      cand_q    <= '0;
      pass_q    <= '0;
      fail_q    <= 1'b0;
      led_q     <= 6'b000001;
      glyph_q   <= msg({G_C, G_L, G_S, G_D});
`ifdef LOCK_LOCKOUT_EN
      tries_q    <= '0;
      lock_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ent_buf_q <= ent_buf_d;
      cand_q    <= cand_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      led_q     <= led_d;
      glyph_q   <= glyph_d;
`ifdef LOCK_LOCKOUT_EN
      tries_q    <= tries_d;
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  assign bus.led   = led_q;
  assign bus.glyph = glyph_q;
endmodule

// File: tb/tb_digital_lock_param.sv
module tb_digital_lock_param;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  localparam logic [19:0] CLSD  = {5'd18, 5'd19, 5'd20, 5'd21};
  localparam logic [19:0] OPEN  = {5'd22, 5'd23, 5'd24, 5'd25};
  localparam logic [19:0] DASHES = {5'd17, 5'd17, 5'd17, 5'd17};
  localparam logic [19:0] BLANKS = {5'd16, 5'd16, 5'd16, 5'd16};

  always #5 clk = ~clk;

  digital_lock_param_if #(.DIGITS(4), .DIGIT_W(4)) bus ();

  digital_lock_param #(
    .DIGITS(4), .DIGIT_W(4), .MAX_TRIES(3), .LOCKOUT_TICKS(2), .TICK_DIV(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; bus.clr = 1'b0; bus.ent = 1'b0; bus.change = 1'b0; bus.sw = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic press(input logic [3:0] v);
    @(negedge clk);
    bus.sw = v; bus.ent = 1'b1;
    @(negedge clk);
    bus.ent = 1'b0;
  endtask

  task automatic pulse_change;
    @(negedge clk);
    bus.change = 1'b1;
    @(negedge clk);
    bus.change = 1'b0;
  endtask

  // Digits are given first-to-last, most significant nibble first.
  task automatic enter_code(input logic [15:0] c);
    for (int i = 0; i < 4; i++) press(c[15-4*i -: 4]);
  endtask

  // One more edge so the registered led/glyph reflect the new state.
  task automatic settle;
    @(negedge clk);
  endtask

  task automatic check_led(input string name, input logic [5:0] exp);
    checks++;
    if (bus.led !== exp) begin
      errors++;
      $display("FAIL %s: led=%b expected %b", name, bus.led, exp);
    end
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (bus.led !== 6'b000001) begin
      errors++; $display("FAIL reset_led: led=%b expected 000001", bus.led);
    end
    checks++;
    if (bus.glyph !== CLSD) begin
      errors++; $display("FAIL reset_glyph: glyph=%h expected %h", bus.glyph, CLSD);
    end
    pulse_change();
    settle();
    checks++;
    if (bus.led !== 6'b000001) begin
      errors++; $display("FAIL change_in_locked: led=%b expected 000001", bus.led);
    end
  endtask

  task automatic test_unlock;
    do_reset();
    press(4'h0);
    settle();
    checks++;
    if (bus.led !== 6'b000100) begin
      errors++; $display("FAIL enter_unlock_led: led=%b expected 000100", bus.led);
    end
    press(4'h0);
    press(4'h7);
    bus.sw = 4'h5;
    settle();
    checks++;
    if (bus.glyph[19:10] !== {5'd17, 5'd17} || bus.glyph[4:0] !== 5'd16) begin
      errors++; $display("FAIL entry_glyph: glyph=%h expected dash,dash,x,blank", bus.glyph);
    end
    checks++;
    if (bus.glyph[9:5] !== 5'd5 && bus.glyph[9:5] !== 5'd16) begin
      errors++; $display("FAIL entry_cursor: pos2=%0d expected 5 or 16", bus.glyph[9:5]);
    end
    do_reset();
    press(4'h0);
    enter_code(16'h0000);
    settle();
    check_led("unlock_led", 6'b000010);
    checks++;
    if (bus.glyph !== OPEN) begin
      errors++; $display("FAIL unlock_glyph: glyph=%h expected %h", bus.glyph, OPEN);
    end
  endtask

  task automatic test_change;
    do_reset();
    press(4'h0);
    enter_code(16'h0000);
    // change and ent together: change wins
    @(negedge clk);
    bus.change = 1'b1; bus.ent = 1'b1;
    @(negedge clk);
    bus.change = 1'b0; bus.ent = 1'b0;
    settle();
    check_led("change_wins", 6'b001100);
    enter_code(16'h1234);
    settle();
    check_led("confirm_mode", 6'b001100);
    enter_code(16'h1234);
    settle();
    check_led("change_done", 6'b000010);
    press(4'h0);
    enter_code(16'h1234);
    settle();
    check_led("relock_new", 6'b000001);
    press(4'h0);
    enter_code(16'h0000);
    settle();
    check_led("old_code_fails", 6'b100001);
    press(4'h0);
    enter_code(16'h1234);
    settle();
    check_led("new_code_unlocks", 6'b000010);
  endtask

  task automatic test_confirm_mismatch;
    do_reset();
    press(4'h0);
    enter_code(16'h0000);
    pulse_change();
    enter_code(16'h1234);
    enter_code(16'h1235);
    settle();
    check_led("confirm_mismatch", 6'b000010);
    press(4'h0);
    enter_code(16'h1234);
    settle();
    check_led("lock_with_rejected", 6'b000010);
    press(4'h0);
    enter_code(16'h0000);
    settle();
    check_led("lock_with_old", 6'b000001);
  endtask

  task automatic test_clear;
    do_reset();
    press(4'h0);
    press(4'h9);
    press(4'h9);
    @(negedge clk);
    bus.sw = 4'h9; bus.clr = 1'b1; bus.ent = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0; bus.ent = 1'b0;
    settle();
    check_led("clear_state", 6'b000100);
    checks++;
    if ((bus.glyph[19:15] !== 5'd9 && bus.glyph[19:15] !== 5'd16) || bus.glyph[14:10] !== 5'd16) begin
      errors++; $display("FAIL clear_glyph: glyph=%h expected cursor at position 0", bus.glyph);
    end
    enter_code(16'h0000);
    settle();
    check_led("clear_then_unlock", 6'b000010);
    press(4'h0);
    enter_code(16'h1111);
    settle();
    check_led("lock_mismatch", 6'b000010);
    press(4'h0);
    enter_code(16'h0000);
    settle();
    check_led("lock_match", 6'b000001);
  endtask

  task automatic test_lockout;
    int n;
    do_reset();
`ifdef LOCK_LOCKOUT_EN
    press(4'h0); enter_code(16'h1111); settle();
    check_led("try1", 6'b100001);
    press(4'h0); enter_code(16'h1111); settle();
    press(4'h0); enter_code(16'h1111); settle();
    check_led("lockout_enter", 6'b110000);
    checks++;
    if (bus.glyph !== DASHES && bus.glyph !== BLANKS) begin
      errors++; $display("FAIL lockout_glyph: glyph=%h expected dashes or blanks", bus.glyph);
    end
    press(4'h0);
    settle();
    check_led("lockout_ignores_ent", 6'b110000);
    n = 0;
    while (bus.led[4] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_led("lockout_exit", 6'b100001);
    press(4'h0); enter_code(16'h2222); settle();
    press(4'h0); enter_code(16'h2222); settle();
    check_led("tries_cleared", 6'b100001);
    press(4'h0); enter_code(16'h2222); settle();
    check_led("lockout_again", 6'b110000);
    n = 0;
    while (bus.led[4] && n < 40) begin
      @(negedge clk);
      n++;
    end
`else
    press(4'h0); enter_code(16'h1111); settle();
    press(4'h0); enter_code(16'h1111); settle();
    press(4'h0); enter_code(16'h1111); settle();
    check_led("no_lockout", 6'b100001);
    n = 0;
`endif
    press(4'h0);
    enter_code(16'h0000);
    settle();
    check_led("unlock_after_fails", 6'b000010);
  endtask

  task automatic test_reset_mid_entry;
    do_reset();
    press(4'h0);
    enter_code(16'h0000);
    pulse_change();
    press(4'h5);
    press(4'h6);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_led("rst_mid_led", 6'b000001);
    checks++;
    if (bus.glyph !== CLSD) begin
      errors++; $display("FAIL rst_mid_glyph: glyph=%h expected %h", bus.glyph, CLSD);
    end
    rst = 1'b0;
    press(4'h0);
    enter_code(16'h0000);
    settle();
    check_led("rst_mid_password", 6'b000010);
  endtask

  initial begin
    bus.clr = 1'b0; bus.ent = 1'b0; bus.change = 1'b0; bus.sw = '0;
    test_reset();
    test_unlock();
    test_change();
    test_confirm_mismatch();
    test_clear();
    test_lockout();
    test_reset_mid_entry();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
